// File: rtl/cla_chunked_subtractor_if.sv
// Operand/result handshake bundle for the chunked CLA subtractor.
// The master side drives operands and accepts results; the slave side is the subtractor.
interface cla_chunked_subtractor_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Diff;
  logic         Bout;
  logic         overflow;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout, overflow
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout, overflow
  );
endinterface

// File: rtl/cla_chunked_subtractor.sv
// Multi-cycle subtractor: Diff = A - B - Bin, computed as A + ~B + ~Bin,
// one W-bit carry-lookahead slice per cycle, LSB slice first.
//
// state | meaning
// IDLE  | ready for operands, in_ready=1
// BUSY  | processing one slice per cycle, carry held between slices
// DONE  | result valid and held until out_ready
module cla_chunked_subtractor #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cla_chunked_subtractor_if.slave bus
);
  localparam int SLICES = N / W;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  nb_q;
  logic          carry_q;
  logic [CW-1:0] cnt;
  logic [N-1:0]  diff_q;
  logic          bout_q;
  logic          ovf_q;
  logic          out_valid_q;

  logic [W-1:0]  a_sl;
  logic [W-1:0]  b_sl;
  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W:0]    c;
  logic [W-1:0]  s;
  logic          prod;
  logic          last;

  // Each carry is a flat OR of generate terms masked by propagate chains,
  // so the slice depth does not grow with ripple through W bits.
  always_comb begin
    a_sl = a_q[cnt*W +: W];
    b_sl = nb_q[cnt*W +: W];
    g    = a_sl & b_sl;
    p    = a_sl ^ b_sl;
    c    = '0;
    prod = 1'b0;
    c[0] = carry_q;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & carry_q);
    end
    s = p ^ c[W-1:0];
  end

  assign last = (cnt == CW'(SLICES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      carry_q     <= 1'b0;
      cnt         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.A;
            nb_q    <= ~bus.B;
            carry_q <= ~bus.Bin;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          diff_q[cnt*W +: W] <= s;
          carry_q            <= c[W];
          cnt                <= cnt + CW'(1);
          if (last) begin
            bout_q      <= ~c[W];
            // Operand signs differ (A msb equals inverted-B msb) and result sign left A's sign
            ovf_q       <= (a_q[N-1] == nb_q[N-1]) && (s[W-1] != a_q[N-1]);
            out_valid_q <= 1'b1;
            cnt         <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = reset_n && (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.Diff      = diff_q;
  assign bus.Bout      = bout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cla_chunked_subtractor.sv
// Directed and swept checks of the chunked subtractor for W = 4, 1, 8 and 16 at N = 16.
module tb_cla_chunked_subtractor;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cla_chunked_subtractor_if #(.N(16)) bus4 ();
  cla_chunked_subtractor_if #(.N(16)) bus1 ();
  cla_chunked_subtractor_if #(.N(16)) bus8 ();
  cla_chunked_subtractor_if #(.N(16)) bus16 ();

  cla_chunked_subtractor #(.N(16), .W(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(bus4));
  cla_chunked_subtractor #(.N(16), .W(1))  dut1  (.clk(clk), .reset_n(reset_n), .bus(bus1));
  cla_chunked_subtractor #(.N(16), .W(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8));
  cla_chunked_subtractor #(.N(16), .W(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));

  task automatic idle_inputs();
    bus4.in_valid = 0;  bus4.A = '0;  bus4.B = '0;  bus4.Bin = 0;  bus4.out_ready = 0;
    bus1.in_valid = 0;  bus1.A = '0;  bus1.B = '0;  bus1.Bin = 0;  bus1.out_ready = 0;
    bus8.in_valid = 0;  bus8.A = '0;  bus8.B = '0;  bus8.Bin = 0;  bus8.out_ready = 0;
    bus16.in_valid = 0; bus16.A = '0; bus16.B = '0; bus16.Bin = 0; bus16.out_ready = 0;
  endtask

  // Drives one operand set into the W=4 instance; returns cycles from accept to out_valid.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin, output int lat);
    @(negedge clk);
    bus4.A = a; bus4.B = b; bus4.Bin = bin; bus4.in_valid = 1;
    @(posedge clk);
    #1 bus4.in_valid = 0;
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume4();
    bus4.out_ready = 1;
    @(posedge clk);
    #1 bus4.out_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus4.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", bus4.in_ready); end
    checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", bus4.out_valid); end
    checks++; if (bus4.Diff !== 16'h0000 || bus4.Bout !== 1'b0 || bus4.overflow !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got Diff=%h Bout=%b ovf=%b expected 0/0/0", bus4.Diff, bus4.Bout, bus4.overflow);
    end
    @(negedge clk) reset_n = 1;
    @(posedge clk);
    #1;
    checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b expected 1", bus4.in_ready); end
  endtask

  task automatic test_basic();
    logic [15:0] va [6] = '{16'h1234, 16'h1000, 16'h0000, 16'h8000, 16'h0005, 16'h7FFF};
    logic [15:0] vb [6] = '{16'h0034, 16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'hFFFF};
    logic        vc [6] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0};
    logic [15:0] ed [6] = '{16'h1200, 16'h0FFF, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000};
    logic        eb [6] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1};
    logic        eo [6] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], vc[i], lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency[%0d] got %0d expected 4", i, lat); end
      checks++; if (bus4.Diff !== ed[i]) begin errors++; $display("FAIL basic_diff[%0d] got %h expected %h", i, bus4.Diff, ed[i]); end
      checks++; if (bus4.Bout !== eb[i]) begin errors++; $display("FAIL basic_bout[%0d] got %b expected %b", i, bus4.Bout, eb[i]); end
      checks++; if (bus4.overflow !== eo[i]) begin errors++; $display("FAIL basic_ovf[%0d] got %b expected %b", i, bus4.overflow, eo[i]); end
      checks++; if (bus4.in_ready !== 1'b0) begin errors++; $display("FAIL basic_done_in_ready[%0d] got %b expected 0", i, bus4.in_ready); end
      consume4();
      checks++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
        errors++; $display("FAIL basic_consume[%0d] got out_valid=%b in_ready=%b expected 0/1", i, bus4.out_valid, bus4.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(16'h7FFF, 16'hFFFF, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d expected 4", lat); end
    bus4.A = 16'hFFFF; bus4.B = 16'h0000; bus4.Bin = 0; bus4.in_valid = 1; bus4.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_flags[%0d] got out_valid=%b in_ready=%b expected 1/0", i, bus4.out_valid, bus4.in_ready);
      end
      checks++; if (bus4.Diff !== 16'h8000 || bus4.Bout !== 1'b1 || bus4.overflow !== 1'b1) begin
        errors++; $display("FAIL bp_hold_data[%0d] got Diff=%h Bout=%b ovf=%b expected 8000/1/1", i, bus4.Diff, bus4.Bout, bus4.overflow);
      end
    end
    bus4.in_valid = 0;
    bus4.out_ready = 1;
    @(posedge clk);
    #1 bus4.out_ready = 0;
    checks++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b expected 0/1", bus4.out_valid, bus4.in_ready);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    @(negedge clk);
    bus4.A = 16'hFFFF; bus4.B = 16'h0000; bus4.Bin = 0; bus4.in_valid = 1;
    @(posedge clk);
    #1 bus4.in_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 0;
    @(posedge clk);
    #1;
    checks++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got out_valid=%b in_ready=%b expected 0/0", bus4.out_valid, bus4.in_ready);
    end
    checks++; if (bus4.Diff !== 16'h0000 || bus4.Bout !== 1'b0 || bus4.overflow !== 1'b0) begin
      errors++; $display("FAIL midreset_data got Diff=%h Bout=%b ovf=%b expected 0000/0/0", bus4.Diff, bus4.Bout, bus4.overflow);
    end
    @(negedge clk) reset_n = 1;
    @(posedge clk);
    #1;
    checks++; if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_release got in_ready=%b out_valid=%b expected 1/0", bus4.in_ready, bus4.out_valid);
    end
    start_op(16'h0003, 16'h0002, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midreset_op_latency got %0d expected 4", lat); end
    checks++; if (bus4.Diff !== 16'h0001 || bus4.Bout !== 1'b0 || bus4.overflow !== 1'b0) begin
      errors++; $display("FAIL midreset_op got Diff=%h Bout=%b ovf=%b expected 0001/0/0", bus4.Diff, bus4.Bout, bus4.overflow);
    end
    consume4();
  endtask

  task automatic test_sweep();
    logic [15:0] a, b, ed;
    logic [16:0] wide;
    logic        bin, eb, eo;
    int          sd, l1, l8, l16, cyc;
    for (int v = 0; v < 10; v++) begin
      case (v)
        0: begin a = 16'h0000; b = 16'hFFFF; bin = 1; end
        1: begin a = 16'h8000; b = 16'h7FFF; bin = 0; end
        2: begin a = 16'hFFFF; b = 16'hFFFF; bin = 0; end
        default: begin a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); end
      endcase
      ed   = a - b - 16'(bin);
      wide = {1'b0, a} - {1'b0, b} - 17'(bin);
      eb   = wide[16];
      sd   = int'($signed(a)) - int'($signed(b)) - int'(bin);
      eo   = (sd > 32767) || (sd < -32768);

      @(negedge clk);
      bus1.A = a;  bus1.B = b;  bus1.Bin = bin;  bus1.in_valid = 1;
      bus8.A = a;  bus8.B = b;  bus8.Bin = bin;  bus8.in_valid = 1;
      bus16.A = a; bus16.B = b; bus16.Bin = bin; bus16.in_valid = 1;
      @(posedge clk);
      #1;
      bus1.in_valid = 0; bus8.in_valid = 0; bus16.in_valid = 0;
      l1 = -1; l8 = -1; l16 = -1; cyc = 0;
      while ((l1 < 0 || l8 < 0 || l16 < 0) && cyc < 40) begin
        @(posedge clk);
        #1 cyc++;
        if (bus1.out_valid && l1 < 0) l1 = cyc;
        if (bus8.out_valid && l8 < 0) l8 = cyc;
        if (bus16.out_valid && l16 < 0) l16 = cyc;
      end
      checks++; if (l1 !== 16 || l8 !== 2 || l16 !== 1) begin
        errors++; $display("FAIL sweep_latency[%0d] got W1=%0d W8=%0d W16=%0d expected 16/2/1", v, l1, l8, l16);
      end
      checks++; if (bus1.Diff !== ed || bus1.Bout !== eb || bus1.overflow !== eo) begin
        errors++; $display("FAIL sweep_w1[%0d] a=%h b=%h bin=%b got %h/%b/%b expected %h/%b/%b", v, a, b, bin, bus1.Diff, bus1.Bout, bus1.overflow, ed, eb, eo);
      end
      checks++; if (bus8.Diff !== ed || bus8.Bout !== eb || bus8.overflow !== eo) begin
        errors++; $display("FAIL sweep_w8[%0d] a=%h b=%h bin=%b got %h/%b/%b expected %h/%b/%b", v, a, b, bin, bus8.Diff, bus8.Bout, bus8.overflow, ed, eb, eo);
      end
      checks++; if (bus16.Diff !== ed || bus16.Bout !== eb || bus16.overflow !== eo) begin
        errors++; $display("FAIL sweep_w16[%0d] a=%h b=%h bin=%b got %h/%b/%b expected %h/%b/%b", v, a, b, bin, bus16.Diff, bus16.Bout, bus16.overflow, ed, eb, eo);
      end
      bus1.out_ready = 1; bus8.out_ready = 1; bus16.out_ready = 1;
      @(posedge clk);
      #1;
      bus1.out_ready = 0; bus8.out_ready = 0; bus16.out_ready = 0;
      checks++; if (bus1.in_ready !== 1'b1 || bus8.in_ready !== 1'b1 || bus16.in_ready !== 1'b1) begin
        errors++; $display("FAIL sweep_return_idle[%0d] got %b%b%b expected 111", v, bus1.in_ready, bus8.in_ready, bus16.in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_busy();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_chunked_subtractor.md
Name: cla_chunked_subtractor

Overview:
- Multi-cycle, handshaked subtractor, the inverse of the team's registered CLA adder: computes Diff = A - B - Bin.
- Reuses one W-bit carry-lookahead slice per cycle, LSB slice first, with a carry register between slices.
- Trades latency for area; sits on datapaths where subtract/compare results can wait N/W cycles.
- Valid/ready on both sides; one operation in flight.

Parameters:
- N, 16, operand/result width; must be an integer multiple of W.
- W, 4, slice width processed per cycle; 1 <= W <= N.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- A  in  N  minuend, two's complement or unsigned.
- B  in  N  subtrahend.
- Bin  in  1  borrow in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Diff  out  N  A - B - Bin mod 2^N.
- Bout  out  1  unsigned borrow out: 1 iff A < B + Bin as unsigned.
- overflow  out  1  signed overflow of A - B - Bin.

Behaviour:
- Reset and clock: reset_n is synchronous and active-low; clk is the clock. Reset is sampled only on the rising edge.
- Reset values: state=IDLE, out_valid=0, Diff=0, Bout=0, overflow=0, slice counter=0, carry=0.
- in_ready is forced 0 while reset_n=0.
- Arithmetic: A + ~B + ~Bin, performed slice-wise. The carry register is initialised to ~Bin at accept.
- Per slice k, s = A[kW+:W] + ~B[kW+:W] + carry, computed with W-bit lookahead generate/propagate.
  - Diff[kW+:W] <= s[W-1:0].
  - carry <= s[W].
- Bout = ~final carry.
- overflow = (A[N-1] != B[N-1]) && (Diff[N-1] != A[N-1]).
- FSM IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: capture A, ~B, carry=~Bin, counter=0, go to BUSY.
- FSM BUSY:
  - in_ready=0. Process slice counter each cycle, counter++.
  - On the last slice (counter == N/W-1), write Bout and overflow in the same edge, set out_valid=1, go to DONE.
- FSM DONE:
  - out_valid=1, in_ready=0. Diff, Bout and overflow are held stable.
  - On out_ready, go to IDLE and clear out_valid.
- Latency: the acceptance edge is t0, and out_valid is high after edge t0+N/W.
  - Minimum initiation interval: N/W+2 cycles. No accept occurs in the same cycle as the output handshake.
- Diff updates only during BUSY slice writes. Bout and overflow update only on the last slice.
- Outputs are meaningful only while out_valid=1; the previous result bits may be partially overwritten during BUSY.
- in_valid during BUSY or DONE is ignored; no operand capture occurs.
- out_ready while not in DONE has no effect.
- Reset asserted in any state aborts the operation, discards the result and applies the reset values at that edge.
- W == N: single-cycle BUSY, so out_valid rises 1 cycle after accept.

Test Plan:
- N=16, W=4: accept A=0x1234, B=0x0034, Bin=0 -> out_valid 4 cycles after accept; Diff=0x1200, Bout=0, overflow=0.
- Borrow ripple through all slices: A=0x1000, B=0x0001, Bin=0 -> Diff=0x0FFF, Bout=0, overflow=0. Also A=0x0000, B=0x0001 -> Diff=0xFFFF, Bout=1, overflow=0.
- Signed overflow and borrow-in:
  - A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, Bout=0, overflow=1.
  - A=0x0005, B=0x0005, Bin=1 -> Diff=0xFFFF, Bout=1, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with A=0xFFFF -> outputs unchanged, in_ready=0, no capture. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-BUSY after 2 slices -> at that edge out_valid=0, Diff=0, Bout=0. After release, in_ready=1, and 0x0003-0x0002 with Bin=0 yields Diff=0x0001, Bout=0.
- Parameter sweep: W=1, 8 and 16 with random operands vs reference model A-B-Bin -> Diff, Bout and overflow match; out_valid exactly N/W cycles after accept.
